fp_div_pipe: RTL and testbench
==============================

# fp_div_pipe

Pipelined signed fixed-point divider for the QMC-LSM datapath. Computes `dividend / divisor` on two's-complement Q(FP_QINT).(FP_QFRAC) operands, one result per cycle, with a fixed latency of FP_DIV_LATENCY cycles. It is the division counterpart of the single-cycle fixed-point multiplier and feeds the regression and normalisation stages. A valid/ready handshake on both sides and a pass-through tag let callers reorder-check results.

## Interface
- WIDTH, FP_WIDTH (32): operand and result width.
- QFRAC, FP_QFRAC (16): fractional bits.
- LATENCY, FP_DIV_LATENCY (16): pipeline depth. Elaboration error unless WIDTH % LATENCY == 0.
- TAG_W, 8: width of the sideband tag.

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands present.
- in_ready  out  1  pipeline can accept this cycle.
- dividend  in  WIDTH  signed Q-format numerator.
- divisor  in  WIDTH  signed Q-format denominator.
- in_tag  in  TAG_W  caller sideband, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- quotient  out  WIDTH  signed Q-format result.
- out_tag  out  TAG_W  tag of this result.
- div_by_zero  out  1  divisor was 0.
- overflow  out  1  result saturated.

## Operation
- Arithmetic: magnitude = floor((|dividend| << QFRAC) / |divisor|). The result is truncated toward zero. Sign = sign(dividend) XOR sign(divisor), applied by two's-complement negation at the last stage.
- Overflow is detected at input time: |dividend| >= (|divisor| << (WIDTH-1-QFRAC)), using WIDTH+1-bit magnitudes.
  - Overflow result: 0x7FFF_FFFF if positive, 0x8000_0000 if negative, with overflow=1.
  - The negative-exact-boundary case is flagged as well, because the saturated value is correct there.
- Divisor == 0 gives div_by_zero=1 and overflow=0. Result is 0x7FFF_FFFF when dividend >= 0, else 0x8000_0000. The special-case flags bypass the arithmetic but travel in the same pipeline slot.
- Algorithm: restoring long division producing WIDTH quotient bits, WIDTH/LATENCY bits per stage (2 at defaults). The partial remainder is WIDTH+1 bits. Stage 0 registers magnitudes, sign, flags and tag.
- Results leave in acceptance order. No reordering and no drops.

## Timing
- Stall rule: advance = !out_valid || out_ready, and in_ready = advance. in_ready is combinational from out_ready.
  - When advance is low, the whole pipeline holds, including bubbles.
- Transfers: accept on in_valid && in_ready at a clock edge. Deliver on out_valid && out_ready.
- Latency: an input accepted at edge k gives out_valid at edge k+LATENCY when no stall occurs. Each stalled cycle adds one cycle.
- Throughput: one result per cycle while out_ready=1.
- While out_valid && !out_ready, quotient, out_tag and the flags are held stable.
- Reset values: every stage-valid=0, out_valid=0, quotient=0, out_tag=0, div_by_zero=0, overflow=0.
  - in_ready=1 during reset, since out_valid=0, but no transfer is accepted while rst_n=0.
- Reset mid-operation discards all in-flight operations. No stale result appears after release.
- Simultaneous accept and deliver in one cycle is the normal streaming case and is required to work.

## Structure
- Shared package fpga_cfg_pkg gains:
  - FP_MAX = 32'h7FFF_FFFF and FP_MIN = 32'h8000_0000.
  - FP_DIV_BITS_PER_STAGE = FP_WIDTH / FP_DIV_LATENCY.
- The stage record typedef (valid, rem, quo, divisor magnitude, sign, dz, ovf, tag) is local to the module because it depends on TAG_W.
- Sub-module fp_div_stage: combinational 2-bit (parameterised) restoring step on remainder/quotient. It is instantiated LATENCY-1 times inside a generate loop, with registers owned by fp_div_pipe.

## Test plan
- 3.0/2.0: 0x0003_0000 / 0x0002_0000, tag 0x11. Expect 0x0001_8000 after exactly 16 cycles, tag 0x11, flags 0.
- -1.0/3.0: 0xFFFF_0000 / 0x0003_0000. Expect 0xFFFF_AAAB (truncation toward zero), flags 0.
- Divide by zero:
  - 0x0001_0000 / 0 gives 0x7FFF_FFFF with div_by_zero=1.
  - 0xFFFF_0000 / 0 gives 0x8000_0000 with div_by_zero=1.
  - 0 / 0 gives 0x7FFF_FFFF.
- Overflow:
  - 0x7FFF_0000 / 0x0000_0100 gives 0x7FFF_FFFF with overflow=1.
  - 0x8000_0000 / 0x0000_0100 gives 0x8000_0000 with overflow=1.
- Streaming backpressure: 200 random operand pairs back-to-back, out_ready random at 50%.
  - All results match the reference model, in order, with tags preserved.
  - No loss or duplication. Outputs stable during stalls.
  - Zero-stall runs achieve 1 result per cycle.
- Reset mid-flight: 8 operations in flight, then rst_n low for 1 cycle. Expect out_valid=0 immediately and no output until new inputs are given. The first new input returns after 16 cycles.

Source files
------------

// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point configuration for the QMC-LSM datapath: Q-format geometry,
// saturation limits and divider pipeline shape.
package fpga_cfg_pkg;

  localparam int unsigned FP_WIDTH       = 32;
  localparam int unsigned FP_QFRAC       = 16;
  localparam int unsigned FP_QINT        = FP_WIDTH - FP_QFRAC;
  localparam int unsigned FP_DIV_LATENCY = 16;

  localparam int unsigned FP_DIV_BITS_PER_STAGE = FP_WIDTH / FP_DIV_LATENCY;

  localparam logic [FP_WIDTH-1:0] FP_MAX = 32'h7FFF_FFFF;
  localparam logic [FP_WIDTH-1:0] FP_MIN = 32'h8000_0000;

endpackage

// File: rtl/fp_div_stage.sv
// Combinational restoring-division step: shifts BITS numerator bits from the
// quotient word into the partial remainder, emitting one quotient bit each.
module fp_div_stage
  import fpga_cfg_pkg::*;
#(
  parameter int unsigned WIDTH = FP_WIDTH,
  parameter int unsigned BITS  = FP_DIV_BITS_PER_STAGE
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH:0]   dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;

  // quo doubles as the numerator shift register: its MSB feeds the remainder
  // while the new quotient bit enters at the LSB.
  always_comb begin
    r = rem_i;
    q = quo_i;
    for (int unsigned i = 0; i < BITS; i++) begin
      r = (r << 1) | {{WIDTH{1'b0}}, q[WIDTH-1]};
      q = q << 1;
      if (r >= dvs_i) begin
        r    = r - dvs_i;
        q[0] = 1'b1;
      end
    end
    rem_o = r;
    quo_o = q;
  end

endmodule

// File: rtl/fp_div_pipe.sv
// Pipelined signed Q-format divider: fixed latency, one result per cycle,
// valid/ready on both sides with a whole-pipe stall and a pass-through tag.
module fp_div_pipe
  import fpga_cfg_pkg::*;
#(
  parameter int unsigned WIDTH   = FP_WIDTH,
  parameter int unsigned QFRAC   = FP_QFRAC,
  parameter int unsigned LATENCY = FP_DIV_LATENCY,
  parameter int unsigned TAG_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [TAG_W-1:0] out_tag,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned BPS       = WIDTH / LATENCY;
  localparam int unsigned OVF_SHIFT = WIDTH - 1 - QFRAC;
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH % LATENCY != 0) begin : g_cfg_err
    $error("fp_div_pipe: WIDTH must be a multiple of LATENCY");
  end

  typedef struct packed {
    logic             valid;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   dvs;
    logic             sign;
    logic             dz;
    logic             ovf;
    logic [TAG_W-1:0] tag;
  } stage_t;

  logic advance;

  logic [WIDTH:0]   ext_a, ext_b, abs_a, abs_b;
  logic [2*WIDTH:0] ovf_lhs, ovf_rhs;
  logic             dz_in, ovf_in;

  logic [WIDTH:0]   stp_rem_i [LATENCY];
  logic [WIDTH-1:0] stp_quo_i [LATENCY];
  logic [WIDTH:0]   stp_dvs_i [LATENCY];
  logic [WIDTH:0]   stp_rem_o [LATENCY];
  logic [WIDTH-1:0] stp_quo_o [LATENCY];

  stage_t st_d [LATENCY];
  stage_t st_q [LATENCY];

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] quotient_d, quotient_q;
  logic [TAG_W-1:0] out_tag_d, out_tag_q;
  logic             dz_d, dz_q;
  logic             ovf_d, ovf_q;

  always_comb begin
    advance = !out_valid_q || out_ready;
  end

  // Magnitudes are WIDTH+1 bits so |MIN| is representable; the overflow
  // compare is widened so the shifted divisor cannot wrap.
  always_comb begin
    ext_a   = {dividend[WIDTH-1], dividend};
    ext_b   = {divisor[WIDTH-1], divisor};
    abs_a   = ext_a[WIDTH] ? -ext_a : ext_a;
    abs_b   = ext_b[WIDTH] ? -ext_b : ext_b;
    dz_in   = (divisor == '0);
    ovf_lhs = {{WIDTH{1'b0}}, abs_a};
    ovf_rhs = {{WIDTH{1'b0}}, abs_b} << OVF_SHIFT;
    ovf_in  = !dz_in && (ovf_lhs >= ovf_rhs);
  end

  // Numerator is abs_a << QFRAC: bits above WIDTH seed the remainder, the
  // low WIDTH bits are shifted in one per quotient bit.
  always_comb begin
    stp_rem_i[0] = abs_a >> (WIDTH - QFRAC);
    stp_quo_i[0] = WIDTH'(abs_a << QFRAC);
    stp_dvs_i[0] = abs_b;
    for (int unsigned g = 1; g < LATENCY; g++) begin
      stp_rem_i[g] = st_q[g-1].rem;
      stp_quo_i[g] = st_q[g-1].quo;
      stp_dvs_i[g] = st_q[g-1].dvs;
    end
  end

  fp_div_stage #(
    .WIDTH (WIDTH),
    .BITS  (BPS)
  ) u_stage0 (
    .rem_i (stp_rem_i[0]),
    .quo_i (stp_quo_i[0]),
    .dvs_i (stp_dvs_i[0]),
    .rem_o (stp_rem_o[0]),
    .quo_o (stp_quo_o[0])
  );

  for (genvar g = 1; g < LATENCY; g++) begin : g_stage
    fp_div_stage #(
      .WIDTH (WIDTH),
      .BITS  (BPS)
    ) u_stage (
      .rem_i (stp_rem_i[g]),
      .quo_i (stp_quo_i[g]),
      .dvs_i (stp_dvs_i[g]),
      .rem_o (stp_rem_o[g]),
      .quo_o (stp_quo_o[g])
    );
  end

  always_comb begin
    st_d[0].valid = in_valid;
    st_d[0].rem   = stp_rem_o[0];
    st_d[0].quo   = stp_quo_o[0];
    st_d[0].dvs   = abs_b;
    st_d[0].sign  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
    st_d[0].dz    = dz_in;
    st_d[0].ovf   = ovf_in;
    st_d[0].tag   = in_tag;
    for (int unsigned g = 1; g < LATENCY; g++) begin
      st_d[g]     = st_q[g-1];
      st_d[g].rem = stp_rem_o[g];
      st_d[g].quo = stp_quo_o[g];
    end
  end

  // With a zero divisor the stored sign is the dividend's sign, so the
  // saturation choice is shared with the overflow case.
  always_comb begin
    out_valid_d = st_q[LATENCY-1].valid;
    out_tag_d   = st_q[LATENCY-1].tag;
    dz_d        = st_q[LATENCY-1].dz;
    ovf_d       = st_q[LATENCY-1].ovf;
    if (st_q[LATENCY-1].dz || st_q[LATENCY-1].ovf) begin
      quotient_d = st_q[LATENCY-1].sign ? SAT_MIN : SAT_MAX;
    end else begin
      quotient_d = st_q[LATENCY-1].sign ? -st_q[LATENCY-1].quo : st_q[LATENCY-1].quo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        st_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      out_tag_q   <= '0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (advance) begin
      st_q        <= st_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      out_tag_q   <= out_tag_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready    = advance;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign out_tag     = out_tag_q;
  assign div_by_zero = dz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_fp_div_pipe.sv
// Scoreboard bench for fp_div_pipe: driver pushes expected results on accept,
// an independent monitor pops and compares on every delivered result.
module tb_fp_div_pipe;
  import fpga_cfg_pkg::*;

  localparam int unsigned W   = 32;
  localparam int unsigned TW  = 8;
  localparam int unsigned LAT = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  quotient;
  logic [TW-1:0] out_tag;
  logic          div_by_zero;
  logic          overflow;

  fp_div_pipe #(
    .WIDTH   (W),
    .QFRAC   (16),
    .LATENCY (LAT),
    .TAG_W   (TW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .out_tag     (out_tag),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  q;
    logic [TW-1:0] tag;
    logic          dz;
    logic          ovf;
    int            acc;
    bit            chk_lat;
  } exp_t;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [TW-1:0] t;
    logic [W-1:0]  q;
    logic          dz;
    logic          ovf;
  } vec_t;

  exp_t scb[$];
  vec_t vecs[14];

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_sent = 0;
  int deliveries = 0;
  int run_len = 0;
  int max_run = 0;
  bit rdy_random = 1'b0;

  bit          hold = 1'b0;
  logic [41:0] held;
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic dz, output logic ovf);
    longint sa, sbv, ma, mb, mag;
    bit neg;
    sa  = longint'(signed'(a));
    sbv = longint'(signed'(b));
    ma  = (sa < 0) ? -sa : sa;
    mb  = (sbv < 0) ? -sbv : sbv;
    neg = (sa < 0) != (sbv < 0);
    dz  = 1'b0;
    ovf = 1'b0;
    if (b == '0) begin
      dz = 1'b1;
      q  = (sa < 0) ? FP_MIN : FP_MAX;
    end else if (ma >= (mb << 15)) begin
      ovf = 1'b1;
      q   = neg ? FP_MIN : FP_MAX;
    end else begin
      mag = (ma << 16) / mb;
      q   = W'(neg ? -mag : mag);
    end
  endfunction

  // Must be called at a falling edge; returns at a falling edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] t,
                      input logic [W-1:0] eq, input logic edz, input logic eovf);
    exp_t e;
    bit done = 1'b0;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    in_tag   = t;
    for (int n = 0; n < 1000 && !done; n++) begin
      #1;
      if (rst_n && in_ready) begin
        e.q       = eq;
        e.tag     = t;
        e.dz      = edz;
        e.ovf     = eovf;
        e.acc     = cyc + 1;
        e.chk_lat = !rdy_random;
        scb.push_back(e);
        n_sent++;
        done = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL send_timeout: tag 0x%0h not accepted, expected acceptance within 1000 cycles", t);
    end
  endtask

  task automatic send_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] t);
    logic [W-1:0] q;
    logic dz, ovf;
    model(a, b, q, dz, ovf);
    send(a, b, t, q, dz, ovf);
  endtask

  task automatic drain();
    int n = 0;
    while (scb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (scb.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", scb.size());
    end
    @(negedge clk);
  endtask

  initial forever begin
    @(negedge clk);
    out_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      hold    = 1'b0;
      run_len = 0;
    end else begin
      if (hold) chk("stall_hold", {out_valid, quotient, out_tag, div_by_zero, overflow}, {1'b1, held});
      if (out_valid && out_ready) begin
        deliveries++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (scb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_out: got tag 0x%0h quotient 0x%0h, expected no result", out_tag, quotient);
        end else begin
          mon_e = scb.pop_front();
          chk("quotient", quotient, mon_e.q);
          chk("out_tag", out_tag, mon_e.tag);
          chk("div_by_zero", div_by_zero, mon_e.dz);
          chk("overflow", overflow, mon_e.ovf);
          if (mon_e.chk_lat) chk("latency", cyc - mon_e.acc, LAT);
        end
      end else begin
        run_len = 0;
      end
      hold = out_valid && !out_ready;
      held = {quotient, out_tag, div_by_zero, overflow};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1);
  end

  initial begin
    int d0;
    vecs[0]  = '{32'h0003_0000, 32'h0002_0000, 8'h11, 32'h0001_8000, 1'b0, 1'b0};
    vecs[1]  = '{32'hFFFF_0000, 32'h0003_0000, 8'h12, 32'hFFFF_AAAB, 1'b0, 1'b0};
    vecs[2]  = '{32'h0001_0000, 32'h0000_0000, 8'h13, 32'h7FFF_FFFF, 1'b1, 1'b0};
    vecs[3]  = '{32'hFFFF_0000, 32'h0000_0000, 8'h14, 32'h8000_0000, 1'b1, 1'b0};
    vecs[4]  = '{32'h0000_0000, 32'h0000_0000, 8'h15, 32'h7FFF_FFFF, 1'b1, 1'b0};
    vecs[5]  = '{32'h7FFF_0000, 32'h0000_0100, 8'h16, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[6]  = '{32'h8000_0000, 32'h0000_0100, 8'h17, 32'h8000_0000, 1'b0, 1'b1};
    vecs[7]  = '{32'h8000_0000, 32'h0001_0000, 8'h18, 32'h8000_0000, 1'b0, 1'b1};
    vecs[8]  = '{32'h7FFF_FFFF, 32'h0001_0000, 8'h19, 32'h7FFF_FFFF, 1'b0, 1'b0};
    vecs[9]  = '{32'h0001_0000, 32'hFFFF_0000, 8'h1A, 32'hFFFF_0000, 1'b0, 1'b0};
    vecs[10] = '{32'hFFFF_8000, 32'h0000_4000, 8'h1B, 32'hFFFE_0000, 1'b0, 1'b0};
    vecs[11] = '{32'h0007_0000, 32'hFFFE_0000, 8'h1C, 32'hFFFC_8000, 1'b0, 1'b0};
    vecs[12] = '{32'h0000_0000, 32'h0005_0000, 8'h1D, 32'h0000_0000, 1'b0, 1'b0};
    vecs[13] = '{32'h0000_0001, 32'h0001_0000, 8'h1E, 32'h0000_0001, 1'b0, 1'b0};

    // Offer an operand during reset: it must never be accepted.
    in_valid = 1'b1;
    dividend = 32'h0004_0000;
    divisor  = 32'h0001_0000;
    in_tag   = 8'hEE;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_quotient", quotient, 32'h0);
    chk("rst_out_tag", out_tag, 8'h0);
    chk("rst_div_by_zero", div_by_zero, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].t, vecs[i].q, vecs[i].dz, vecs[i].ovf);
    drain();

    max_run = 0;
    for (int i = 0; i < 32; i++) send_model($urandom, $urandom, 8'(8'h40 + i));
    drain();
    chk("throughput_run", max_run, 32);

    rdy_random = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] a, b;
      int sel;
      a   = $urandom >> $urandom_range(0, 16);
      sel = $urandom_range(0, 9);
      if (sel == 0)     b = '0;
      else if (sel < 3) b = $urandom >> $urandom_range(8, 31);
      else              b = $urandom;
      if ($urandom_range(0, 1) == 1) a = -a;
      send_model(a, b, 8'(i));
    end
    rdy_random = 1'b0;
    drain();
    chk("delivery_count", deliveries, n_sent);

    for (int i = 0; i < 8; i++) send_model(32'h0002_0000 + i, 32'h0001_0000, 8'(8'hA0 + i));
    repeat (2) @(negedge clk);
    d0 = deliveries;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    scb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (24) @(negedge clk);
    chk("no_stale_output", deliveries, d0);
    send(32'h0003_0000, 32'h0002_0000, 8'h5A, 32'h0001_8000, 1'b0, 1'b0);
    drain();
    chk("post_rst_delivery", deliveries, d0 + 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
